sap_reg_bank: RTL and testbench

Parametrised bank of general-purpose registers for the SAP datapath, generalising the single 8-bit B/output register. It holds DEPTH registers of WIDTH bits and performs one operation per clock on a selected entry: load from bus, increment, decrement, shift or clear. It drives the selected entry onto the shared tri-state bus and exposes all entries unbuffered to the ALU and display. It sits on the main bus alongside the A register and ALU, and is controlled by the control sequencer.

---
 rtl/sap_reg_bank.sv | 111 +++++++++++
 tb/tb_sap_reg_bank.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sap_reg_bank.sv
// sap_reg_bank: bank of DEPTH x WIDTH general-purpose registers with per-cycle load/inc/dec/shift/clear on one selected entry.
// Ports:
//   i_clk          rising-edge clock
//   i_reset        asynchronous active-high reset; entries <= RESET_VALUE, flags <= 0, o_bus released
//   i_debug        simulation trace of every write (no effect on logic)
//   i_sel          entry targeted by i_op and i_bus_out_en; values >= DEPTH are ignored
//   i_op           000 hold, 001 load, 010 inc, 011 dec, 100 shl, 101 shr, 110 clear, 111 hold
//   i_bus          load data
//   i_bus_out_en   drive the selected entry onto o_bus
//   o_bus          tri-state bus driver, high-Z unless enabled with a valid select
//   o_unbuffered   every entry, entry k at [k*WIDTH +: WIDTH]
//   o_zero/o_carry flags of the last executed operation
// Optional feature: define REG_BANK_FLAGS_EN to build the flag registers; otherwise the flags are tied to 0.
module sap_reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_debug,
  input  logic [SELW-1:0]        i_sel,
  input  logic [2:0]             i_op,
  input  logic [WIDTH-1:0]       i_bus,
  input  logic                   i_bus_out_en,
  output tri logic [WIDTH-1:0]   o_bus,
  output logic [DEPTH*WIDTH-1:0] o_unbuffered,
  output logic                   o_zero,
  output logic                   o_carry
);
  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             w_sel_valid;
  logic             w_write;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_new;

  assign w_sel_valid = 32'(i_sel) < DEPTH;
  assign w_old       = w_sel_valid ? r_regs[i_sel] : '0;
  assign w_write     = w_sel_valid && (i_op != OP_HOLD) && (i_op != OP_RSVD);

  always_comb begin
    w_new = w_old;
    case (i_op)
      OP_LOAD:  w_new = i_bus;
      OP_INC:   w_new = w_old + WIDTH'(1);
      OP_DEC:   w_new = w_old - WIDTH'(1);
      OP_SHL:   w_new = {w_old[WIDTH-2:0], 1'b0};
      OP_SHR:   w_new = {1'b0, w_old[WIDTH-1:1]};
      OP_CLEAR: w_new = '0;
      default:  w_new = w_old;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= RESET_VALUE;
    end else begin
      for (int k = 0; k < DEPTH; k++) if (w_write && 32'(i_sel) == k) r_regs[k] <= w_new;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_unbuf
      assign o_unbuffered[g*WIDTH +: WIDTH] = r_regs[g];
    end
  endgenerate

  // Released during reset regardless of the enable so the bus is free while the datapath resets.
  assign o_bus = (i_bus_out_en && w_sel_valid && !i_reset) ? w_old : 'z;

`ifdef REG_BANK_FLAGS_EN
  logic w_cout;
  logic r_zero;
  logic r_carry;
  assign w_cout = (i_op == OP_INC) ? &w_old :
                  (i_op == OP_DEC) ? ~|w_old :
                  (i_op == OP_SHL) ? w_old[WIDTH-1] :
                  (i_op == OP_SHR) ? w_old[0] : 1'b0;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_write) begin
      r_zero  <= (w_new == '0);
      r_carry <= w_cout;
    end
  end
  assign o_zero  = r_zero;
  assign o_carry = r_carry;
`else
  assign o_zero  = 1'b0;
  assign o_carry = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (!i_reset && i_debug && w_write) $display("sap_reg_bank: r[%0d] op=%0d <= %h", i_sel, i_op, w_new);
  end
`endif
endmodule

// File: tb/tb_sap_reg_bank.sv
// tb_sap_reg_bank: directed self-checking bench for sap_reg_bank (DEPTH=4 and DEPTH=3 instances sharing stimulus).
module tb_sap_reg_bank;
`ifdef REG_BANK_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [1:0] sel;
  logic [2:0] op;
  logic [7:0] bus_in;
  logic en;
  tri1 [7:0] bus_a;
  tri1 [7:0] bus_b;
  logic [31:0] unb_a;
  logic [23:0] unb_b;
  logic zero_a, carry_a, zero_b, carry_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sap_reg_bank #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h5A)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_debug(1'b0), .i_sel(sel), .i_op(op), .i_bus(bus_in),
    .i_bus_out_en(en), .o_bus(bus_a), .o_unbuffered(unb_a), .o_zero(zero_a), .o_carry(carry_a));

  sap_reg_bank #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h5A)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_debug(1'b0), .i_sel(sel), .i_op(op), .i_bus(bus_in),
    .i_bus_out_en(en), .o_bus(bus_b), .o_unbuffered(unb_b), .o_zero(zero_b), .o_carry(carry_b));

  function automatic logic [7:0] ea(int k);
    return unb_a[k*8 +: 8];
  endfunction

  function automatic logic [7:0] eb(int k);
    return unb_b[k*8 +: 8];
  endfunction

  task automatic drive(input logic [1:0] s, input logic [2:0] o, input logic [7:0] d, input logic e);
    @(negedge clk);
    sel = s; op = o; bus_in = d; en = e;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] s, input logic [2:0] o, input logic [7:0] d);
    drive(s, o, d, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    step(2'd0, 3'b001, 8'h11);
    step(2'd3, 3'b110, 8'h00);
    drive(2'd0, 3'b000, 8'h00, 1'b1);
    checks++; if (bus_a !== 8'h11) begin errors++; $display("FAIL pre_reset_bus got %h exp 11", bus_a); end
    checks++; if (zero_a !== FL) begin errors++; $display("FAIL pre_reset_zero got %b exp %b", zero_a, FL); end
    op = 3'b001; bus_in = 8'h99;
    #2 rst = 1'b1;
    #1;
    checks++; if (unb_a !== {4{8'h5A}}) begin errors++; $display("FAIL reset_entries got %h exp 5a5a5a5a", unb_a); end
    checks++; if (zero_a !== 1'b0 || carry_a !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", zero_a, carry_a); end
    checks++; if (bus_a !== 8'hFF) begin errors++; $display("FAIL reset_bus_z got %h exp released", bus_a); end
    tick();
    checks++; if (unb_a !== {4{8'h5A}}) begin errors++; $display("FAIL reset_hold_entries got %h exp 5a5a5a5a", unb_a); end
    @(negedge clk);
    rst = 1'b0; op = 3'b000; en = 1'b0;
    checks++; if (unb_b !== {3{8'h5A}}) begin errors++; $display("FAIL reset_entries_b got %h exp 5a5a5a", unb_b); end
  endtask

  task automatic test_load();
    step(2'd2, 3'b001, 8'hC3);
    checks++; if (ea(2) !== 8'hC3) begin errors++; $display("FAIL load_e2 got %h exp c3", ea(2)); end
    checks++; if (ea(0) !== 8'h5A || ea(1) !== 8'h5A || ea(3) !== 8'h5A) begin errors++; $display("FAIL load_others got %h exp 5a5a5a", {ea(3), ea(1), ea(0)}); end
    checks++; if (zero_a !== 1'b0 || carry_a !== 1'b0) begin errors++; $display("FAIL load_flags got %b%b exp 00", zero_a, carry_a); end
    drive(2'd2, 3'b000, 8'h00, 1'b1);
    checks++; if (bus_a !== 8'hC3) begin errors++; $display("FAIL load_bus got %h exp c3", bus_a); end
    checks++; if (bus_b !== 8'hC3) begin errors++; $display("FAIL load_bus_b got %h exp c3", bus_b); end
    en = 1'b0;
    #1;
    checks++; if (bus_a !== 8'hFF) begin errors++; $display("FAIL bus_disabled got %h exp released", bus_a); end
  endtask

  task automatic test_wrap();
    step(2'd1, 3'b001, 8'hFF);
    step(2'd1, 3'b010, 8'h00);
    checks++; if (ea(1) !== 8'h00) begin errors++; $display("FAIL inc_wrap got %h exp 00", ea(1)); end
    checks++; if (zero_a !== FL || carry_a !== FL) begin errors++; $display("FAIL inc_wrap_flags got %b%b exp %b%b", zero_a, carry_a, FL, FL); end
    step(2'd1, 3'b011, 8'h00);
    checks++; if (ea(1) !== 8'hFF) begin errors++; $display("FAIL dec_wrap got %h exp ff", ea(1)); end
    checks++; if (zero_a !== 1'b0 || carry_a !== FL) begin errors++; $display("FAIL dec_wrap_flags got %b%b exp 0%b", zero_a, carry_a, FL); end
  endtask

  task automatic test_shift();
    step(2'd0, 3'b001, 8'h81);
    step(2'd0, 3'b100, 8'h00);
    checks++; if (ea(0) !== 8'h02 || carry_a !== FL || zero_a !== 1'b0) begin errors++; $display("FAIL shl got %h c%b z%b exp 02 c%b z0", ea(0), carry_a, zero_a, FL); end
    step(2'd0, 3'b101, 8'h00);
    checks++; if (ea(0) !== 8'h01 || carry_a !== 1'b0 || zero_a !== 1'b0) begin errors++; $display("FAIL shr1 got %h c%b z%b exp 01 c0 z0", ea(0), carry_a, zero_a); end
    step(2'd0, 3'b101, 8'h00);
    checks++; if (ea(0) !== 8'h00 || carry_a !== FL || zero_a !== FL) begin errors++; $display("FAIL shr2 got %h c%b z%b exp 00 c%b z%b", ea(0), carry_a, zero_a, FL, FL); end
  endtask

  task automatic test_boundary();
    drive(2'd3, 3'b001, 8'h77, 1'b1);
    checks++; if (bus_b !== 8'hFF) begin errors++; $display("FAIL bad_sel_bus got %h exp released", bus_b); end
    tick();
    checks++; if (unb_b !== 24'hC3FF00) begin errors++; $display("FAIL bad_sel_entries got %h exp c3ff00", unb_b); end
    checks++; if (zero_b !== FL || carry_b !== FL) begin errors++; $display("FAIL bad_sel_flags got %b%b exp %b%b", zero_b, carry_b, FL, FL); end
    checks++; if (ea(3) !== 8'h77 || zero_a !== 1'b0 || carry_a !== 1'b0) begin errors++; $display("FAIL sel3_depth4 got %h z%b c%b exp 77 z0 c0", ea(3), zero_a, carry_a); end
    drive(2'd0, 3'b001, 8'h3C, 1'b1);
    checks++; if (bus_a !== 8'h00) begin errors++; $display("FAIL bus_load_old got %h exp 00", bus_a); end
    tick();
    checks++; if (ea(0) !== 8'h3C || bus_a !== 8'h3C) begin errors++; $display("FAIL bus_load_new got %h bus %h exp 3c", ea(0), bus_a); end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    step(2'd2, 3'b010, 8'h00);
    step(2'd2, 3'b010, 8'h00);
    checks++; if (ea(2) !== 8'hC5) begin errors++; $display("FAIL inc_inc got %h exp c5", ea(2)); end
    step(2'd3, 3'b011, 8'h00);
    checks++; if (ea(3) !== 8'h76 || carry_a !== 1'b0) begin errors++; $display("FAIL dec got %h c%b exp 76 c0", ea(3), carry_a); end
    step(2'd2, 3'b111, 8'h00);
    step(2'd2, 3'b000, 8'h00);
    checks++; if (unb_a !== 32'h76C5FF3C) begin errors++; $display("FAIL hold got %h exp 76c5ff3c", unb_a); end
    step(2'd1, 3'b110, 8'h00);
    checks++; if (ea(1) !== 8'h00 || zero_a !== FL || carry_a !== 1'b0) begin errors++; $display("FAIL clear got %h z%b c%b exp 00 z%b c0", ea(1), zero_a, carry_a, FL); end
  endtask

  initial begin
    rst = 1'b1; sel = '0; op = '0; bus_in = '0; en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_load();
    test_wrap();
    test_shift();
    test_boundary();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
